// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: control-flag bit layout, packed control type, NOP encoding.
package mem_wb_pkg;

    localparam int CTRL_BITS       = 8;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_JUMP       = 5;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_HALT       = 7;

    // Field order mirrors the bit indices above (regWrite is bit 0).
    typedef struct packed {
        logic halt;
        logic aluSrc;
        logic jump;
        logic branch;
        logic memWrite;
        logic memRead;
        logic memToReg;
        logic regWrite;
    } ctrl_t;

    localparam logic [31:0] NOP_IR = 32'h0;

    function automatic logic ctrlRegWrite(input ctrl_t ctrl);
        return ctrl.regWrite;
    endfunction

endpackage

// File: rtl/mem_wb_stage_skid.sv
// Generic 2-entry valid/ready skid buffer; upstream ready comes only from the skid-valid flop and rst.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] outData
);

    logic         vld_p1;
    logic         skidVld_p1;
    logic [W-1:0] data_p1;
    logic [W-1:0] skidData_p1;
    logic         accept;
    logic         retire;

    assign inReady  = ~skidVld_p1 & ~rst;
    assign accept   = inValid & inReady;
    assign retire   = vld_p1 & outReady;
    assign outValid = vld_p1;
    assign outData  = data_p1;

    // ---- stage p1: main (output) register and skid register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skidVld_p1  <= 1'b0;
            data_p1     <= '0;
            skidData_p1 <= '0;
        end else if (flush) begin
            // Data is left as-is; only the valid bits are killed.
            vld_p1     <= 1'b0;
            skidVld_p1 <= 1'b0;
        end else if (skidVld_p1) begin
            // inReady is low here, so no accept can coincide with the refill.
            if (retire) begin
                data_p1    <= skidData_p1;
                vld_p1     <= 1'b1;
                skidVld_p1 <= 1'b0;
            end
        end else if (!vld_p1 || retire) begin
            vld_p1 <= accept;
            if (accept) begin
                data_p1 <= inData;
            end
        end else if (accept) begin
            skidData_p1 <= inData;
            skidVld_p1  <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: writeback mux at capture, skid-buffered handshake, zero-register write guard.
// Optional build macro MEM_WB_PERF_EN adds stall_cnt / bubble_cnt performance counters.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int REG_AW         = 5,
    parameter int CTRL_W         = CTRL_BITS,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_ir,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_load,
    input  logic [REG_AW-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_ir,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write
`ifdef MEM_WB_PERF_EN
   ,output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam int   PAYLOAD_W = CTRL_W + 2 * DATA_W + REG_AW;
    localparam logic GUARD_ON  = (ZERO_REG_GUARD != 0);

    function automatic logic [DATA_W-1:0] wbSelect(
        input logic              memToReg,
        input logic [DATA_W-1:0] load,
        input logic [DATA_W-1:0] result
    );
        return memToReg ? load : result;
    endfunction

    logic [DATA_W-1:0]    wbData_p0;
    logic [PAYLOAD_W-1:0] payload_p0;
    logic [PAYLOAD_W-1:0] payload_p1;
    logic                 vld_p1;
    logic                 rdIsZero;

    // ---- stage p0: select writeback data and pack the entry ----
    assign wbData_p0  = wbSelect(in_ctrl[CTRL_MEM_TO_REG], in_load, in_result);
    assign payload_p0 = {in_ctrl, in_ir, wbData_p0, in_rd};

    pipe_skid_buf #(
        .W(PAYLOAD_W)
    ) uSkid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .inData   (payload_p0),
        .outValid (vld_p1),
        .outReady (out_ready),
        .outData  (payload_p1)
    );

    // ---- stage p1: unpack held entry and qualify the register write ----
    assign {out_ctrl, out_ir, out_wb_data, out_rd} = payload_p1;
    assign out_valid     = vld_p1;
    assign rdIsZero      = (out_rd == '0);
    assign out_reg_write = vld_p1 & out_ctrl[CTRL_REG_WRITE] & ~(GUARD_ON & rdIsZero);

`ifdef MEM_WB_PERF_EN
    // Counters wrap naturally and are deliberately untouched by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (vld_p1 && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!vld_p1) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (perf counters checked when MEM_WB_PERF_EN is defined).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_ir;
    logic [31:0] in_result;
    logic [31:0] in_load;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [31:0] out_ir;
    logic [31:0] out_wb_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
`ifdef MEM_WB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W(32), .REG_AW(5), .CTRL_W(8), .ZERO_REG_GUARD(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ctrl       (in_ctrl),
        .in_ir         (in_ir),
        .in_result     (in_result),
        .in_load       (in_load),
        .in_rd         (in_rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctrl      (out_ctrl),
        .out_ir        (out_ir),
        .out_wb_data   (out_wb_data),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
`ifdef MEM_WB_PERF_EN
       ,.stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] ir,
                         input logic [31:0] res, input logic [31:0] ld, input logic [4:0] rd);
        in_valid  = v;
        in_ctrl   = c;
        in_ir     = ir;
        in_result = res;
        in_load   = ld;
        in_rd     = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);

        // Reset held two cycles
        tick();
        chk("rst_in_ready_c1", in_ready, 0);
        tick();
        chk("rst_in_ready_c2", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_reg_write", out_reg_write, 0);
        chk("rst_out_ir", out_ir, 0);
        chk("rst_out_wb_data", out_wb_data, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        tick();
        chk("idle_out_valid", out_valid, 0);

        // Streaming: four back-to-back entries, out_ready high
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h01, 32'h1000 + i, 32'h10 + i, 32'hFFFF0000, 5'(i + 1));
            tick();
            chk($sformatf("str%0d_valid", i), out_valid, 1);
            chk($sformatf("str%0d_wb", i), out_wb_data, 32'h10 + i);
            chk($sformatf("str%0d_rd", i), out_rd, i + 1);
            chk($sformatf("str%0d_ir", i), out_ir, 32'h1000 + i);
            chk($sformatf("str%0d_regw", i), out_reg_write, 1);
            chk($sformatf("str%0d_ready", i), in_ready, 1);
        end
        drive(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("str_drain_valid", out_valid, 0);
        chk("str_drain_regw", out_reg_write, 0);

        // Skid fill: A then B with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 32'hA, 32'hA0, 32'h0, 5'd5);
        tick();
        chk("skA_valid", out_valid, 1);
        chk("skA_wb", out_wb_data, 32'hA0);
        chk("skA_ready", in_ready, 1);
        drive(1'b1, 8'h01, 32'hB, 32'hB0, 32'h0, 5'd6);
        tick();
        chk("skB_held_wb", out_wb_data, 32'hA0);
        chk("skB_held_rd", out_rd, 5);
        chk("skB_ready_low", in_ready, 0);
        drive(1'b1, 8'h01, 32'hC, 32'hC0, 32'h0, 5'd9);
        tick();
        chk("sk_stall_wb", out_wb_data, 32'hA0);
        chk("sk_stall_ready", in_ready, 0);
        drive(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);
        out_ready = 1'b1;
        tick();
        chk("skB_out_valid", out_valid, 1);
        chk("skB_out_wb", out_wb_data, 32'hB0);
        chk("skB_out_rd", out_rd, 6);
        chk("skB_ready_back", in_ready, 1);
        tick();
        chk("sk_drain_valid", out_valid, 0);

        // Writeback select and zero-register guard
        drive(1'b1, 8'h03, 32'h77, 32'h5, 32'hDEADBEEF, 5'd7);
        tick();
        chk("wb_load_sel", out_wb_data, 32'hDEADBEEF);
        chk("wb_load_regw", out_reg_write, 1);
        chk("wb_load_ctrl", out_ctrl, 8'h03);
        drive(1'b1, 8'h01, 32'h78, 32'h55, 32'h12345678, 5'd0);
        tick();
        chk("rd0_valid", out_valid, 1);
        chk("rd0_wb", out_wb_data, 32'h55);
        chk("rd0_regw", out_reg_write, 0);
        drive(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("hold_valid", out_valid, 0);
        chk("hold_wb", out_wb_data, 32'h55);
        chk("hold_regw", out_reg_write, 0);

        // Flush with main and skid full
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 32'hD, 32'hD0, 32'h0, 5'd10);
        tick();
        drive(1'b1, 8'h01, 32'hE, 32'hE0, 32'h0, 5'd11);
        tick();
        chk("fl_full_ready", in_ready, 0);
        chk("fl_full_wb", out_wb_data, 32'hD0);
        flush = 1'b1;
        drive(1'b1, 8'h01, 32'hF, 32'hF0, 32'h0, 5'd12);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_regw", out_reg_write, 0);
        drive(1'b1, 8'h01, 32'h9, 32'h90, 32'h0, 5'd13);
        tick();
        chk("fl_accept_dropped", out_valid, 0);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("fl_nothing_emerges", out_valid, 0);
        drive(1'b1, 8'h01, 32'h8, 32'h80, 32'h0, 5'd14);
        tick();
        chk("fl_recover_valid", out_valid, 1);
        chk("fl_recover_wb", out_wb_data, 32'h80);

        // Reset in the middle of a stall
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 32'h6, 32'h60, 32'h0, 5'd15);
        tick();
        chk("mr_full_ready", in_ready, 0);
        rst = 1'b1;
        drive(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_wb", out_wb_data, 0);
        chk("mr_ir", out_ir, 0);
        chk("mr_ctrl", out_ctrl, 0);
        chk("mr_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("mr_rel_ready", in_ready, 1);

        // Perf: one accept, three stalled cycles, retire, two empty cycles
        drive(1'b1, 8'h01, 32'h3, 32'h30, 32'h0, 5'd3);
        tick();
        drive(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        tick();
        chk("pf_stall_valid", out_valid, 1);
        chk("pf_stall_wb", out_wb_data, 32'h30);
        out_ready = 1'b1;
        tick();
        chk("pf_retired", out_valid, 0);
        tick();
        tick();
`ifdef MEM_WB_PERF_EN
        chk("pf_stall_cnt", stall_cnt, 3);
        chk("pf_bubble_ge2", (bubble_cnt >= 32'd2), 1);
        chk("pf_bubble_cnt", bubble_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
